// File: rtl/local_bias_ctrl.sv
// Local bias sequencer: debounced supply qualification, pdb power-up with settle, ATB break-before-make switching.
// Power-up takes 1+DEBOUNCE_CYCLES+SETTLE_CYCLES cycles; an ATB change acks 2+ATB_SETTLE_CYCLES cycles after request.
module local_bias_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int SETTLE_CYCLES     = 16,
  parameter int ATB_SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  real        vddana_1p8,
  input  real        vddana_0p8,
  input  real        vssana,
  input  logic       atb_req,
  input  logic [0:1] atb_sel,
  output logic       pdb,
  output logic [0:1] atb_ena,
  output logic       bias_ready,
  output logic       atb_ack,
  output logic       fault,
  output logic [7:0] fault_cnt
);

  typedef enum logic [2:0] {
    OFF,
    SUPPLY_WAIT,
    POWER_UP,
    READY,
    ATB_BREAK,
    ATB_SETTLE,
    FAULT
  } state_t;

  localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] SET_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] ATB_LAST = 16'(ATB_SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [0:1]  atb_cur_q, atb_cur_d;
  logic [0:1]  atb_pend_q, atb_pend_d;
  logic        atb_ack_q, atb_ack_d;
  logic [7:0]  fault_cnt_q, fault_cnt_d;

  logic supply_ok;
  logic powered;

  assign supply_ok = (vddana_1p8 >= 1.71)  && (vddana_1p8 <= 1.89) &&
                     (vddana_0p8 >= 0.76)  && (vddana_0p8 <= 0.84) &&
                     (vssana     >= -0.05) && (vssana     <= 0.05);

  assign powered = (state_q == POWER_UP) || (state_q == READY) ||
                   (state_q == ATB_BREAK) || (state_q == ATB_SETTLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    atb_cur_d   = atb_cur_q;
    atb_pend_d  = atb_pend_q;
    atb_ack_d   = 1'b0;
    fault_cnt_d = fault_cnt_q;

    if (!en) begin
      // Dropping enable wins over a simultaneous supply loss, so no fault is counted.
      state_d   = OFF;
      cnt_d     = '0;
      atb_cur_d = 2'b00;
    end else if (powered && !supply_ok) begin
      state_d     = FAULT;
      cnt_d       = '0;
      fault_cnt_d = (fault_cnt_q != 8'hFF) ? fault_cnt_q + 8'd1 : fault_cnt_q;
    end else begin
      case (state_q)
        OFF: begin
          state_d = SUPPLY_WAIT;
          cnt_d   = '0;
        end
        SUPPLY_WAIT: begin
          if (!supply_ok) begin
            cnt_d = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = POWER_UP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        POWER_UP: begin
          if (cnt_q == SET_LAST) begin
            state_d = READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        READY: begin
          if (atb_req) begin
            if (atb_sel != atb_cur_q) begin
              atb_pend_d = atb_sel;
              state_d    = ATB_BREAK;
            end else begin
              atb_ack_d = 1'b1;
            end
          end
        end
        ATB_BREAK: begin
          atb_cur_d = atb_pend_q;
          state_d   = ATB_SETTLE;
          cnt_d     = '0;
        end
        ATB_SETTLE: begin
          // Requests arriving here, including on the completing cycle, are dropped.
          if (cnt_q == ATB_LAST) begin
            state_d   = READY;
            cnt_d     = '0;
            atb_ack_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= OFF;
      cnt_q       <= '0;
      atb_cur_q   <= 2'b00;
      atb_pend_q  <= 2'b00;
      atb_ack_q   <= 1'b0;
      fault_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      atb_cur_q   <= atb_cur_d;
      atb_pend_q  <= atb_pend_d;
      atb_ack_q   <= atb_ack_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign pdb        = powered;
  assign bias_ready = (state_q == READY) || (state_q == ATB_BREAK) || (state_q == ATB_SETTLE);
  assign fault      = (state_q == FAULT);
  assign atb_ena    = ((state_q == READY) || (state_q == ATB_SETTLE)) ? atb_cur_q : 2'b00;
  assign atb_ack    = atb_ack_q;
  assign fault_cnt  = fault_cnt_q;

endmodule

// File: tb/tb_local_bias_ctrl.sv
// Directed bench for local_bias_ctrl: timeline model checked every cycle plus literal timing checks.
module tb_local_bias_ctrl;

  localparam int DEB = 4;
  localparam int SET = 16;
  localparam int ATB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  real        v18 = 1.8;
  real        v08 = 0.8;
  real        vss = 0.0;
  logic       atb_req = 1'b0;
  logic [0:1] atb_sel = 2'b00;
  logic       pdb;
  logic [0:1] atb_ena;
  logic       bias_ready;
  logic       atb_ack;
  logic       fault;
  logic [7:0] fault_cnt;

  int nvec = 0;
  int nerr = 0;
  logic chk_on = 1'b0;

  local_bias_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .SETTLE_CYCLES(SET),
    .ATB_SETTLE_CYCLES(ATB)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .vddana_1p8(v18), .vddana_0p8(v08), .vssana(vss),
    .atb_req(atb_req), .atb_sel(atb_sel),
    .pdb(pdb), .atb_ena(atb_ena), .bias_ready(bias_ready),
    .atb_ack(atb_ack), .fault(fault), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  // Model: session flag, consecutive-good run, cycles since pdb rose, age of an ATB switch.
  bit         m_on = 0;
  bit         m_fault = 0;
  bit         m_ack = 0;
  int         m_good = 0;
  int         m_pwr = 0;
  int         m_sw = 0;
  logic [0:1] m_cur = 2'b00;
  logic [0:1] m_pend = 2'b00;
  int         m_fcnt = 0;

  function automatic bit sup_ok(input real a, input real b, input real c);
    return (a >= 1.71) && (a <= 1.89) && (b >= 0.76) && (b <= 0.84) && (c >= -0.05) && (c <= 0.05);
  endfunction

  initial forever begin
    @(posedge clk);
    m_ack = 0;
    if (rst) begin
      m_on = 0; m_fault = 0; m_good = 0; m_pwr = 0; m_sw = 0; m_cur = 2'b00; m_fcnt = 0;
    end else if (!en) begin
      m_on = 0; m_fault = 0; m_good = 0; m_pwr = 0; m_sw = 0; m_cur = 2'b00;
    end else if (!m_on) begin
      m_on = 1; m_good = 0;
    end else if (m_fault) begin
      m_fault = 1;
    end else if (m_pwr > 0 && !sup_ok(v18, v08, vss)) begin
      m_fault = 1; m_pwr = 0; m_sw = 0;
      if (m_fcnt < 255) m_fcnt++;
    end else if (m_pwr == 0) begin
      m_good = sup_ok(v18, v08, vss) ? m_good + 1 : 0;
      if (m_good == DEB) begin
        m_pwr = 1; m_good = 0;
      end
    end else begin
      m_pwr++;
      if (m_sw > 0) begin
        m_sw++;
        if (m_sw == 2) m_cur = m_pend;
        if (m_sw == ATB + 2) begin
          m_sw = 0; m_ack = 1;
        end
      end else if (m_pwr > SET + 1 && atb_req) begin
        if (atb_sel != m_cur) begin
          m_pend = atb_sel; m_sw = 1;
        end else begin
          m_ack = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      logic [13:0] exp_v, act_v;
      logic        e_rdy;
      logic [0:1]  e_ena;
      e_rdy = (m_pwr > SET);
      e_ena = (e_rdy && m_sw != 1) ? m_cur : 2'b00;
      exp_v = {(m_pwr > 0), e_ena, e_rdy, m_ack, m_fault, 8'(m_fcnt)};
      act_v = {pdb, atb_ena, bias_ready, atb_ack, fault, fault_cnt};
      nvec++;
      if (act_v !== exp_v) begin
        nerr++;
        $display("FAIL model @%0t: {pdb,ena,rdy,ack,fault,cnt} got %b expected %b", $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(2);
    chk_on = 1'b1;
    chk("rst_pdb", 32'(pdb), 0);
    chk("rst_ena", 32'(atb_ena), 0);
    chk("rst_rdy", 32'(bias_ready), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_cnt", 32'(fault_cnt), 0);
    rst = 1'b0;

    // Power-up timeline from en rise.
    en = 1'b1;
    cyc(4);  chk("pu_pdb_early", 32'(pdb), 0);
    cyc(1);  chk("pu_pdb_rise", 32'(pdb), 1);
    cyc(15); chk("pu_rdy_early", 32'(bias_ready), 0);
    cyc(1);  chk("pu_rdy_rise", 32'(bias_ready), 1);
    chk("pu_ena", 32'(atb_ena), 0);

    // Source change 00 -> 01 with break-before-make.
    atb_sel = 2'b01; atb_req = 1'b1;
    cyc(1); atb_req = 1'b0;
    chk("sw_break", 32'(atb_ena), 0);
    cyc(1); chk("sw_new", 32'(atb_ena), 32'h1);
    cyc(7); chk("sw_ack_early", 32'(atb_ack), 0);
    cyc(1); chk("sw_ack", 32'(atb_ack), 1);
    cyc(1); chk("sw_ack_pulse", 32'(atb_ack), 0);

    // Same source: immediate ack, no gap.
    atb_req = 1'b1;
    cyc(1); atb_req = 1'b0;
    chk("same_ack", 32'(atb_ack), 1);
    chk("same_ena", 32'(atb_ena), 32'h1);
    cyc(1);

    // Supplies on their inclusive window edges stay good.
    v18 = 1.71; v08 = 0.84; vss = -0.05;
    cyc(3); chk("edge_rdy", 32'(bias_ready), 1);
    v18 = 1.89; v08 = 0.76; vss = 0.05;
    cyc(3); chk("edge_rdy2", 32'(bias_ready), 1);
    v18 = 1.8; v08 = 0.8; vss = 0.0;

    // Supply loss during ATB settle.
    atb_sel = 2'b10; atb_req = 1'b1;
    cyc(1); atb_req = 1'b0;
    cyc(3);
    v18 = 1.60;
    cyc(1); v18 = 1.8;
    chk("flt_pdb", 32'(pdb), 0);
    chk("flt_ena", 32'(atb_ena), 0);
    chk("flt_flag", 32'(fault), 1);
    chk("flt_cnt", 32'(fault_cnt), 1);
    cyc(12); chk("flt_sticky", 32'(fault), 1);
    en = 1'b0;
    cyc(1); chk("flt_clr", 32'(fault), 0);
    chk("flt_cnt_kept", 32'(fault_cnt), 1);

    // Re-enable with debounce restart; request during power-up is dropped.
    en = 1'b1;
    cyc(2);
    v08 = 0.75;
    cyc(3); v08 = 0.80;
    cyc(3); chk("deb_pdb_early", 32'(pdb), 0);
    cyc(1); chk("deb_pdb", 32'(pdb), 1);
    atb_sel = 2'b11; atb_req = 1'b1;
    cyc(1); atb_req = 1'b0;
    chk("pu_req_drop", 32'(atb_ack), 0);
    cyc(16); chk("re_rdy", 32'(bias_ready), 1);
    chk("re_ena_cleared", 32'(atb_ena), 0);

    // en drop and supply drop together: no fault counted.
    en = 1'b0; v18 = 1.6;
    cyc(1); v18 = 1.8;
    chk("off_fault", 32'(fault), 0);
    chk("off_cnt", 32'(fault_cnt), 1);
    chk("off_pdb", 32'(pdb), 0);

    // Saturate the fault counter.
    for (int i = 0; i < 256; i++) begin
      en = 1'b1;
      cyc(6);
      v18 = 1.6;
      cyc(1);
      v18 = 1.8; en = 1'b0;
      cyc(1);
    end
    chk("sat_cnt", 32'(fault_cnt), 255);

    // Reset during power-up.
    en = 1'b1;
    cyc(7); chk("rpu_pdb", 32'(pdb), 1);
    rst = 1'b1;
    cyc(1);
    chk("rpu_pdb0", 32'(pdb), 0);
    chk("rpu_cnt0", 32'(fault_cnt), 0);
    chk("rpu_fault0", 32'(fault), 0);
    rst = 1'b0; en = 1'b0;
    cyc(3);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/local_bias_ctrl.md
# local_bias_ctrl

Sequencer for the local bias generator. It watches the three analog supplies and qualifies them against ±5% windows with a debounce, then powers up the bias block through `pdb` and waits for the bias currents to settle before flagging ready. In the ready state it schedules analog test bus (ATB) source changes with break-before-make. It sits between the digital control domain and the local bias real-number model.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive supply-good cycles required before power-up (≥1).
- `SETTLE_CYCLES`, default 16: bias settle time after `pdb` rises (≥1).
- `ATB_SETTLE_CYCLES`, default 8: ATB settle time after a source switch (≥1).

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  bias enable request, level-sensitive.
- `vddana_1p8`  in  real  1.8 V supply; good window 1.71–1.89 V inclusive.
- `vddana_0p8`  in  real  0.8 V supply; good window 0.76–0.84 V inclusive.
- `vssana`  in  real  ground; good window −0.05–0.05 V inclusive.
- `atb_req`  in  1  single-cycle ATB change request.
- `atb_sel`  in  [0:1]  requested ATB source code, sampled with `atb_req`.
- `pdb`  out  1  bias power-down bar, drives the bias block.
- `atb_ena`  out  [0:1]  ATB source select, drives the bias block.
- `bias_ready`  out  1  bias currents valid.
- `atb_ack`  out  1  one-cycle pulse: requested ATB source is stable.
- `fault`  out  1  supply lost while powered; sticky.
- `fault_cnt`  out  8  saturating count of fault entries.

## Operation
- `supply_ok` is combinational: all three supplies are inside their windows.
- States: OFF, SUPPLY_WAIT, POWER_UP, READY, ATB_BREAK, ATB_SETTLE, FAULT.
- Output decode from registered state:
  - `pdb`=1 in POWER_UP, READY, ATB_BREAK and ATB_SETTLE.
  - `bias_ready`=1 in READY, ATB_BREAK and ATB_SETTLE.
  - `fault`=1 in FAULT only.
  - `atb_ena`=00 in every state except READY and ATB_SETTLE, where it equals the `atb_cur` register.
- OFF: when `en`=1, go to SUPPLY_WAIT and clear the counter.
- SUPPLY_WAIT: the counter increments while `supply_ok`=1 and clears to 0 when `supply_ok`=0. When count = DEBOUNCE_CYCLES−1 and `supply_ok`=1, go to POWER_UP and clear the counter.
- POWER_UP: count SETTLE_CYCLES cycles, then go to READY.
- READY:
  - `atb_req` with `atb_sel`≠`atb_cur`: capture `atb_sel` into `atb_pend` and go to ATB_BREAK.
  - `atb_req` with `atb_sel`=`atb_cur`: pulse `atb_ack` next cycle and stay in READY.
- ATB_BREAK: lasts exactly 1 cycle (`atb_ena`=00). Then set `atb_cur`←`atb_pend` and go to ATB_SETTLE.
- ATB_SETTLE: count ATB_SETTLE_CYCLES cycles, then go to READY with `atb_ack`=1 for that first READY cycle.
- FAULT is entered from POWER_UP, READY, ATB_BREAK or ATB_SETTLE when `supply_ok`=0 in any cycle (no debounce on loss).
  - On entry: `fault_cnt` increments, saturating at 255.
  - Exit: only via `en`=0, which goes to OFF.
- Priority, highest first: `rst`, then `en`=0 (any state → OFF; no fault counted even if supplies drop the same cycle), then supply loss, then `atb_req`.
- `atb_req` outside READY is dropped: no ack and no capture. A request in the same cycle as ATB_SETTLE completion is dropped.
- On entry to OFF, `atb_cur` clears to 00. `fault_cnt` clears only on `rst`.

## Timing
- Reset values: state OFF, `pdb`=0, `atb_ena`=00, `bias_ready`=0, `atb_ack`=0, `fault`=0, `fault_cnt`=0, counter 0, `atb_cur`=00.
- `en` sampled high at cycle t with supplies good:
  - SUPPLY_WAIT from t+1.
  - `pdb`=1 at t+1+DEBOUNCE_CYCLES (defaults: t+5).
  - `bias_ready`=1 at t+1+DEBOUNCE_CYCLES+SETTLE_CYCLES (defaults: t+21).
- ATB request at cycle r (source change):
  - `atb_ena`=00 at r+1.
  - New code on `atb_ena` from r+2.
  - `atb_ack` at r+2+ATB_SETTLE_CYCLES (defaults: r+10).
- ATB request at cycle r (same source): `atb_ack` at r+1.
- Supply loss at cycle f: `pdb`=0, `atb_ena`=00, `bias_ready`=0 and `fault`=1 at f+1.
- `en` low at cycle e: OFF, with all outputs at reset values except `fault_cnt`, at e+1.
- `rst` mid-sequence: reset values at the next edge; in-flight ATB request abandoned with no ack.

## Test plan
- Defaults, supplies 1.8/0.8/0.0 V, `en`↑ at cycle 0 → `pdb`↑ at 5, `bias_ready`↑ at 21, `atb_ena`=00.
- `vddana_0p8`=0.75 V during SUPPLY_WAIT, then 0.80 V → debounce restarts; `pdb` rises 4 cycles after the supply returns plus 1.
- READY with `atb_cur`=00; `atb_req` with `atb_sel`=01 at r → `atb_ena` 00 at r+1, 01 at r+2, `atb_ack` pulse at r+10. Repeat with `atb_sel`=01 → ack at r+1, no 00 gap.
- In ATB_SETTLE, `vddana_1p8` drops to 1.60 V → next cycle `pdb`=0, `atb_ena`=00, `fault`=1, `fault_cnt`=1, no ack. Restore supply → stays in FAULT until `en`=0, then OFF; re-enable repeats power-up.
- `en`=0 and a supply drop in the same cycle while READY → OFF, `fault`=0, `fault_cnt` unchanged.
- Force 256 fault entries → `fault_cnt` saturates at 255. `rst` asserted during POWER_UP → all outputs at reset values next cycle.
